// File: rtl/bit_stream_tx_pkg.sv
// Shared definitions for the bit_stream_tx serial test-pattern transmitter:
// FSM state encoding, PRBS7 constants and the default datapath width.
package bit_stream_tx_pkg;

    localparam int CLK_LEN_DEFAULT = 32;

    // PRBS7 x^7 + x^6 + 1, all-ones seed so the first seven bits out are 1
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        PRBS     = 2'd3
    } state_t;

    // One Fibonacci step: shift toward the MSB, feedback from the tapped bits
    function automatic logic [6:0] prbs7_next(input logic [6:0] lfsr);
        return {lfsr[5:0], ^(lfsr & PRBS7_TAPS)};
    endfunction

endpackage

// File: rtl/bit_stream_tx_bit_timer.sv
// Bit-period timer: counts 0..period-1 while running, flags the last cycle
// of each bit and produces an ideal 50%-ish reference bit clock.
module bit_timer
    import bit_stream_tx_pkg::*;
#(
    parameter int CLK_LEN = CLK_LEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    input  logic [CLK_LEN-1:0] i_period,
    output logic               o_bit_strobe,
    output logic               o_clk_ref
);

    logic [CLK_LEN-1:0] r_count;
    logic               w_terminal;

    assign w_terminal   = (r_count == (i_period - CLK_LEN'(1)));
    assign o_bit_strobe = i_run && w_terminal;
    assign o_clk_ref    = i_run && (r_count < (i_period >> 1));

    // Period counter: held at zero while stopped, wraps after the last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (!i_run || w_terminal) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CLK_LEN'(1);
        end
    end

endmodule

// File: rtl/bit_stream_tx.sv
// Serial NRZ frame transmitter: alternating preamble followed by either
// MSB-first user words (back-to-back while valid) or a free-running PRBS7.
//
// state    | meaning
// IDLE     | line low, waiting for a word (mode 0) or enable (mode 1)
// PREAMBLE | sending PREAMBLE_BITS bits of 1,0,1,0...
// DATA     | shifting out user words, chaining on a last-bit transfer
// PRBS     | sending PRBS7 until enable is low at a bit boundary
module bit_stream_tx
    import bit_stream_tx_pkg::*;
#(
    parameter int CLK_LEN       = CLK_LEN_DEFAULT,
    parameter int DATA_W        = 8,
    parameter int PREAMBLE_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    input  logic [CLK_LEN-1:0] bit_period,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic               signal_out,
    output logic               clk_ref,
    output logic               bit_strobe,
    output logic               busy
);

    localparam int BIT_MAX   = (PREAMBLE_BITS > DATA_W) ? PREAMBLE_BITS : DATA_W;
    localparam int BIT_CNT_W = $clog2(BIT_MAX + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_PRE  = BIT_CNT_W'(PREAMBLE_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
    localparam logic [CLK_LEN-1:0]   MIN_PERIOD = CLK_LEN'(2);

    state_t                r_state;
    state_t                w_state_next;
    logic [CLK_LEN-1:0]    r_eff_period;
    logic                  r_mode;
    logic [BIT_CNT_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0]     r_shift;
    logic [6:0]            r_lfsr;
    logic                  w_run;
    logic                  w_bit_strobe;
    logic                  w_last_pre;
    logic                  w_last_bit;
    logic                  w_xfer;
    logic                  w_start;

    assign w_run      = (r_state != IDLE);
    assign w_last_pre = (r_bit_idx == LAST_PRE);
    assign w_last_bit = (r_bit_idx == LAST_DATA);
    assign w_xfer     = s_valid && s_ready;
    assign w_start    = (r_state == IDLE) && (w_state_next == PREAMBLE);
    assign busy       = w_run;
    assign bit_strobe = w_bit_strobe;

    bit_timer #(
        .CLK_LEN (CLK_LEN)
    ) u_bit_timer (
        .clk          (clk),
        .rst          (rst),
        .i_run        (w_run),
        .i_period     (r_eff_period),
        .o_bit_strobe (w_bit_strobe),
        .o_clk_ref    (clk_ref)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, handshake and line output decode
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        signal_out   = 1'b0;
        case (r_state)
            IDLE: begin
                s_ready = enable && !mode;
                if (mode ? enable : (s_valid && s_ready)) begin
                    w_state_next = PREAMBLE;
                end
            end
            PREAMBLE: begin
                signal_out = ~r_bit_idx[0];
                if (w_bit_strobe && w_last_pre) begin
                    w_state_next = r_mode ? PRBS : DATA;
                end
            end
            DATA: begin
                signal_out = r_shift[DATA_W-1];
                s_ready    = w_bit_strobe && w_last_bit && enable && !mode;
                if (w_bit_strobe && w_last_bit && !(s_valid && s_ready)) begin
                    w_state_next = IDLE;
                end
            end
            PRBS: begin
                signal_out = r_lfsr[6];
                if (w_bit_strobe && !enable) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Frame configuration captured once per frame; mid-frame changes ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eff_period <= MIN_PERIOD;
            r_mode       <= 1'b0;
        end else if (w_start) begin
            r_eff_period <= (bit_period < MIN_PERIOD) ? MIN_PERIOD : bit_period;
            r_mode       <= mode;
        end
    end

    // Bit index within the preamble or the current data word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx <= '0;
        end else if (r_state == IDLE || r_state == PRBS) begin
            r_bit_idx <= '0;
        end else if (w_bit_strobe) begin
            if ((r_state == PREAMBLE && w_last_pre) || (r_state == DATA && w_last_bit)) begin
                r_bit_idx <= '0;
            end else begin
                r_bit_idx <= r_bit_idx + BIT_CNT_W'(1);
            end
        end
    end

    // Data shift register: load on transfer, otherwise shift MSB-first per bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_xfer) begin
            r_shift <= s_data;
        end else if (r_state == DATA && w_bit_strobe) begin
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end
    end

    // PRBS7 generator, reseeded at every frame start so each frame is identical
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= PRBS7_SEED;
        end else if (w_start) begin
            r_lfsr <= PRBS7_SEED;
        end else if (r_state == PRBS && w_bit_strobe) begin
            r_lfsr <= prbs7_next(r_lfsr);
        end
    end

endmodule

// File: tb/tb_bit_stream_tx.sv
// Self-checking bench for bit_stream_tx: table of frames, randomized frames,
// a long PRBS run and a mid-frame reset, all against a bit-list model.
module tb_bit_stream_tx;

    localparam int CLK_LEN = 32;
    localparam int DATA_W  = 8;
    localparam int PRE     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               mode;
    logic [CLK_LEN-1:0] bit_period;
    logic [DATA_W-1:0]  s_data;
    logic               s_valid;
    logic               s_ready;
    logic               signal_out;
    logic               clk_ref;
    logic               bit_strobe;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit dut_prbs[$];

    typedef struct {
        int          period;
        bit          md;
        int          nwords;
        logic [23:0] words;
        int          nprbs;
        int          en_off;
        int          exp_busy;
    } vec_t;

    bit_stream_tx #(
        .CLK_LEN       (CLK_LEN),
        .DATA_W        (DATA_W),
        .PREAMBLE_BITS (PRE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .bit_period (bit_period),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .signal_out (signal_out),
        .clk_ref    (clk_ref),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // md=0: en_off is the frame cycle where enable falls (-1 = never).
    // md=1: en_off is the cycle offset inside the last PRBS bit where enable falls.
    task automatic run_frame(input string nm, input int period, input bit md,
                             input int nwords, input logic [23:0] words,
                             input int nprbs, input int en_off, input int exp_busy);
        int   eff, cut, ncyc, mism, first_cyc, busy_cnt, b, c, cur, k;
        bit   en;
        bit   bits[$];
        bit   lastw[$];
        bit   prbs[$];
        logic [4:0] got, want, first_got, first_want;

        eff = (period < 2) ? 2 : period;
        for (int i = 0; i < PRE; i++) begin
            bits.push_back(i % 2 == 0);
            lastw.push_back(1'b0);
        end
        if (!md) begin
            cut = (en_off < 0) ? 32'h7fff_ffff : en_off;
            for (k = 0; k < nwords; k++) begin
                for (int j = DATA_W - 1; j >= 0; j--) begin
                    bits.push_back(words[k*8 + j]);
                    lastw.push_back(j == 0);
                end
                if (bits.size() * eff - 1 >= cut) break;
            end
        end else begin
            dut_prbs.delete();
            for (int i = 0; i < 7; i++) prbs.push_back(1'b1);
            while (prbs.size() < nprbs) prbs.push_back(prbs[prbs.size()-7] ^ prbs[prbs.size()-6]);
            for (int i = 0; i < nprbs; i++) begin
                bits.push_back(prbs[i]);
                lastw.push_back(1'b0);
            end
            cut = (PRE + nprbs - 1) * eff + en_off;
        end

        @(negedge clk);
        bit_period = CLK_LEN'(period);
        mode       = md;
        enable     = 1'b1;
        s_valid    = !md;
        s_data     = words[7:0];
        #1;
        check({nm, ".start_ready"}, int'(s_ready), int'(!md));

        ncyc = bits.size() * eff;
        mism = 0;
        busy_cnt = 0;
        first_cyc = -1;
        first_got = '0;
        first_want = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            b  = cyc / eff;
            c  = cyc % eff;
            en = (cyc < cut);
            @(negedge clk);
            enable     = en;
            bit_period = CLK_LEN'($urandom_range(0, 15));
            if (!md) begin
                mode = 1'b0;
                cur  = (b < PRE) ? 0 : (b - PRE) / DATA_W;
                if (cur + 1 < nwords) begin
                    s_valid = 1'b1;
                    s_data  = words[(cur+1)*8 +: 8];
                end else begin
                    s_valid = 1'b0;
                    s_data  = DATA_W'($urandom);
                end
            end else begin
                mode    = 1'($urandom_range(0, 1));
                s_valid = 1'($urandom_range(0, 1));
                s_data  = DATA_W'($urandom);
            end
            #1;
            want = {bits[b], c == eff - 1, c < eff / 2, 1'b1,
                    (!md && lastw[b] && c == eff - 1 && en)};
            got  = {signal_out, bit_strobe, clk_ref, busy, s_ready};
            if (busy === 1'b1) busy_cnt++;
            if (got !== want) begin
                if (mism == 0) begin
                    first_cyc  = cyc;
                    first_got  = got;
                    first_want = want;
                end
                mism++;
            end
            if (md && b >= PRE && c == eff - 1) dut_prbs.push_back(signal_out);
        end

        @(negedge clk);
        enable  = 1'b0;
        s_valid = 1'b0;
        mode    = 1'b0;
        #1;
        check({nm, ".idle_after"}, int'({signal_out, bit_strobe, clk_ref, busy, s_ready}), 0);

        n_tests++;
        if (mism != 0) begin
            n_fail++;
            $display("FAIL %s.wave: %0d bad cycles of %0d, first at cycle %0d got sig/stb/ref/busy/rdy=%b required %b",
                     nm, mism, ncyc, first_cyc, first_got, first_want);
        end
        if (exp_busy >= 0) check({nm, ".busy_cycles"}, busy_cnt, exp_busy);
    endtask

    initial begin
        vec_t tbl[9];
        int   mism, ones, nstb, p, eff, md, nw, np, off;

        tbl[0] = '{6,  1'b0, 1, 24'h0000A5, 0, -1, 144};
        tbl[1] = '{1,  1'b0, 1, 24'h00003C, 0, -1, 48};
        tbl[2] = '{3,  1'b0, 2, 24'h0000FF, 0, -1, 96};
        tbl[3] = '{0,  1'b0, 1, 24'h000081, 0, -1, 48};
        tbl[4] = '{4,  1'b1, 0, 24'h000000, 7,  0, 92};
        tbl[5] = '{10, 1'b1, 0, 24'h000000, 3,  2, 190};
        tbl[6] = '{2,  1'b0, 3, 24'h563412, 0, -1, 80};
        tbl[7] = '{5,  1'b1, 0, 24'h000000, 1,  4, 85};
        tbl[8] = '{2,  1'b0, 3, 24'hAAF00F, 0, 35, 48};

        rst        = 1'b1;
        enable     = 1'b0;
        mode       = 1'b0;
        bit_period = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.outputs", int'({signal_out, bit_strobe, clk_ref, busy, s_ready}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("idle.no_start", int'({signal_out, bit_strobe, clk_ref, busy}), 0);

        for (int i = 0; i < 9; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].period, tbl[i].md, tbl[i].nwords,
                      tbl[i].words, tbl[i].nprbs, tbl[i].en_off, tbl[i].exp_busy);
        end

        // Long PRBS run: seed bits and 127-bit repetition
        run_frame("prbs_long", 4, 1'b1, 0, 24'h0, 156, 0, -1);
        check("prbs_long.nbits", dut_prbs.size(), 156);
        ones = 0;
        for (int i = 0; i < 7 && i < dut_prbs.size(); i++) ones += int'(dut_prbs[i]);
        check("prbs_long.first7_ones", ones, 7);
        mism = 0;
        for (int i = 0; i + 127 < dut_prbs.size(); i++) if (dut_prbs[i] != dut_prbs[i+127]) mism++;
        check("prbs_long.period127", mism, 0);

        // Reset in the middle of a data word
        @(negedge clk);
        bit_period = 4;
        mode       = 1'b0;
        enable     = 1'b1;
        s_valid    = 1'b1;
        s_data     = 8'hA5;
        @(negedge clk);
        s_valid = 1'b0;
        repeat ((PRE + 2) * 4 + 1) @(negedge clk);
        #1;
        check("rst_mid.sig_before", int'(signal_out), 1);
        check("rst_mid.busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_mid.sig_busy_now", int'({signal_out, busy, clk_ref, bit_strobe}), 0);
        nstb = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (bit_strobe !== 1'b0 || busy !== 1'b0) nstb++;
        end
        check("rst_mid.held_quiet", nstb, 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid.idle_after", int'({signal_out, busy}), 0);
        run_frame("rst_mid.restart", 3, 1'b0, 1, 24'h00005A, 0, -1, 72);

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            p   = $urandom_range(0, 7);
            eff = (p < 2) ? 2 : p;
            md  = $urandom_range(0, 1);
            nw  = $urandom_range(1, 3);
            np  = $urandom_range(1, 20);
            if (md == 1) off = $urandom_range(0, eff - 1);
            else         off = ($urandom_range(0, 2) == 0) ? $urandom_range(0, (PRE + 3*DATA_W) * eff) : -1;
            run_frame($sformatf("rand%0d", r), p, md[0], nw, 24'($urandom), np, off, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_stream_tx.md
BIT_STREAM_TX -- requirements
Module: bit_stream_tx

Interface
REQ-001 The module SHALL have parameter CLK_LEN, default 32, setting the width of the bit-period and counter datapath.
REQ-002 The module SHALL have parameter DATA_W, default 8, setting the width of a user data word.
REQ-003 The module SHALL have parameter PREAMBLE_BITS, default 16, setting the number of alternating preamble bits sent per frame.
REQ-004 The module SHALL have port clk, input, 1, the single clock, sampled on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-006 The module SHALL have port enable, input, 1, which permits frame start and continuation.
REQ-007 The module SHALL have port mode, input, 1, which selects user data (0) or PRBS7 (1).
REQ-008 The module SHALL have port bit_period, input, CLK_LEN, giving the bit length in clk cycles.
REQ-009 The module SHALL have port s_data, input, DATA_W, the user word, transmitted MSB first.
REQ-010 The module SHALL have port s_valid, input, 1, which marks s_data as valid.
REQ-011 The module SHALL have port s_ready, output, 1, which shows the word is accepted this cycle.
REQ-012 The module SHALL have port signal_out, output, 1, the serial NRZ stream that feeds the clock-recovery receiver.
REQ-013 The module SHALL have port clk_ref, output, 1, the ideal bit clock, which lets the bench compare it with the recovered clock.
REQ-014 The module SHALL have port bit_strobe, output, 1, a one-cycle pulse on the last clk cycle of every bit.
REQ-015 The module SHALL have port busy, output, 1, which is high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, PREAMBLE, DATA, PRBS.
REQ-017 In IDLE the module SHALL hold signal_out=0, clk_ref=0 and bit_strobe=0, and SHALL keep the bit counter at 0.
REQ-018 On entry to PREAMBLE the module SHALL latch bit_period as eff_period; a bit_period value below 2 SHALL be treated as 2, and eff_period SHALL stay fixed until the next IDLE.
REQ-019 The bit counter SHALL count 0..eff_period-1 and then wrap to 0; bit_strobe SHALL be high exactly when counter==eff_period-1.
REQ-020 clk_ref SHALL be 1 while counter < (eff_period>>1) and 0 otherwise, in every non-IDLE state.
REQ-021 s_ready SHALL be combinational and equal to (IDLE & enable & ~mode) | (DATA & bit_strobe & last_bit & enable & ~mode).
REQ-022 A word SHALL transfer exactly when s_valid & s_ready; the accepted word SHALL be loaded into the shift register.
REQ-023 IDLE->PREAMBLE SHALL occur on a transfer when mode=0, or on enable=1 when mode=1; signal_out SHALL show the first preamble bit on the next cycle.
REQ-024 PREAMBLE SHALL send PREAMBLE_BITS bits alternating 1,0,1,0,... with each bit lasting eff_period cycles.
REQ-025 After the last preamble bit_strobe, the FSM SHALL go to DATA when mode=0 or to PRBS when mode=1.
REQ-026 In DATA, signal_out SHALL equal the shift-register MSB, and the register SHALL shift left by one on each bit_strobe.
REQ-027 On the last_bit strobe, the FSM SHALL stay in DATA with no gap bit if a transfer occurs; otherwise it SHALL go to IDLE.
REQ-028 PRBS SHALL use polynomial x^7+x^6+1 with seed 7'h7F, SHALL set signal_out=lfsr[6], and SHALL step the LFSR on each bit_strobe.
REQ-029 The LFSR SHALL be reseeded with 7'h7F on every IDLE->PREAMBLE transition.
REQ-030 In PRBS, enable=0 SHALL cause IDLE only at the next bit_strobe, and the current bit SHALL never be truncated.
REQ-031 Changes to mode or bit_period while busy SHALL be ignored until IDLE.
REQ-032 When enable falls in DATA, the current word SHALL complete and no new word SHALL be accepted.

Reset
REQ-033 Asserting rst SHALL immediately force state=IDLE, counter=0, shift register=0, lfsr=7'h7F, eff_period=2, and signal_out, clk_ref, bit_strobe, busy and s_ready-qualifying state to 0.
REQ-034 rst asserted mid-frame SHALL abort the frame and SHALL NOT generate a partial bit_strobe.

Structure
REQ-035 A shared package SHALL hold the state enum, the PRBS7 seed/taps constants and the CLK_LEN default.
REQ-036 One sub-module, bit_timer, SHALL implement the period counter, bit_strobe and clk_ref.

Verification
REQ-037 The bench SHALL check: bit_period=6, mode=0, one word 8'hA5 -> 16 preamble bits of 6 cycles each, then 1,0,1,0,0,1,0,1, then IDLE; busy is high for 144 cycles.
REQ-038 The bench SHALL check: bit_period=1 -> eff_period=2 and bit_strobe every 2nd cycle.
REQ-039 The bench SHALL check: back-to-back words 8'hFF then 8'h00 with s_valid held high -> 8 ones then 8 zeros with no gap, and s_ready pulses exactly at the last-bit strobes.
REQ-040 The bench SHALL check: mode=1, bit_period=4, enable high -> after the preamble the first 7 PRBS bits are 1,1,1,1,1,1,1 and the sequence repeats every 127 bits.
REQ-041 The bench SHALL check: enable dropped 2 cycles into a PRBS bit with bit_period=10 -> that bit lasts the full 10 cycles, then IDLE.
REQ-042 The bench SHALL check: rst pulsed mid-DATA -> signal_out=0 and busy=0 in the same cycle, and the next frame restarts with the preamble.
